// File: rtl/watch_pkg.sv
// Shared types, limits and BCD helper for the watch time counter.
package watch_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mode_t;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd2_t;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   // Converts a 0-99 integer into a {tens, ones} BCD pair.
   function automatic bcd2_t to_bcd(input int value);
      bcd_digit_t tens;
      bcd_digit_t ones;
      tens = 4'(value / 10);
      ones = 4'(value % 10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/watch_time_counter_if.sv
// Button/tick inputs and BCD display outputs of the watch time counter.
interface watch_time_counter_if;
   logic       seconds_pulse_i;
   logic       mode_i;
   logic       inc_i;
   logic [7:0] hours_bcd_o;
   logic [7:0] minutes_bcd_o;
   logic [7:0] seconds_bcd_o;
   logic [1:0] mode_o;
   logic       blink_o;
   logic       day_pulse_o;

   modport master (
      output seconds_pulse_i, mode_i, inc_i,
      input  hours_bcd_o, minutes_bcd_o, seconds_bcd_o, mode_o, blink_o, day_pulse_o
   );

   modport slave (
      input  seconds_pulse_i, mode_i, inc_i,
      output hours_bcd_o, minutes_bcd_o, seconds_bcd_o, mode_o, blink_o, day_pulse_o
   );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; carry_o flags the wrapping increment.
module bcd_mod_counter
   import watch_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic  clk_100MHz_i,
   input  logic  reset_n_i,
   input  logic  en_i,
   input  logic  clr_i,
   input  bcd2_t rst_val_i,
   output bcd2_t value_o,
   output logic  carry_o
);

   localparam bcd2_t MAX_BCD = to_bcd(MAX);

   bcd2_t value_reg;
   bcd2_t value_next;

   // Next value: clear wins, otherwise BCD increment with whole-field wrap.
   always_comb begin
      value_next = value_reg;
      if (clr_i) begin
         value_next = '0;
      end else if (en_i) begin
         if (value_reg == MAX_BCD) begin
            value_next = '0;
         end else if (value_reg[3:0] == 4'd9) begin
            value_next = {value_reg[7:4] + 4'd1, 4'd0};
         end else begin
            value_next = {value_reg[7:4], value_reg[3:0] + 4'd1};
         end
      end
   end

   // Field register, loaded with the reset value asynchronously.
   always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         value_reg <= rst_val_i;
      end else begin
         value_reg <= value_next;
      end
   end

   assign value_o = value_reg;
   assign carry_o = en_i && !clr_i && (value_reg == MAX_BCD);

endmodule

// File: rtl/watch_time_counter.sv
// Wall-clock BCD time keeper with RUN / SET_HOUR / SET_MIN mode control.
module watch_time_counter
   import watch_pkg::*;
#(
   parameter int RESET_HOURS   = 12,
   parameter int RESET_MINUTES = 0
) (
   input logic                 clk_100MHz_i,
   input logic                 reset_n_i,
   watch_time_counter_if.slave bus
);

   // Field index 0 = seconds, 1 = minutes, 2 = hours.
   bcd2_t      field_value [3];
   bcd2_t      field_reset [3];
   logic [2:0] field_en;
   logic [2:0] field_clr;
   logic [2:0] field_carry;

   mode_t mode_reg;
   mode_t mode_next;
   logic  blink_reg;
   logic  blink_next;
   logic  day_pulse_reg;
   logic  day_pulse_next;

   logic in_run;
   logic inc_ok;

   assign field_reset[0] = '0;
   assign field_reset[1] = to_bcd(RESET_MINUTES);
   assign field_reset[2] = to_bcd(RESET_HOURS);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_field
         bcd_mod_counter #(
            .MAX((gi == 2) ? HOUR_MAX : ((gi == 1) ? MIN_MAX : SEC_MAX))
         ) u_cnt (
            .clk_100MHz_i (clk_100MHz_i),
            .reset_n_i    (reset_n_i),
            .en_i         (field_en[gi]),
            .clr_i        (field_clr[gi]),
            .rst_val_i    (field_reset[gi]),
            .value_o      (field_value[gi]),
            .carry_o      (field_carry[gi])
         );
      end
   endgenerate

   // Mode sequencing, field enables/clears, blink phase and day pulse.
   always_comb begin
      mode_next      = mode_reg;
      blink_next     = 1'b0;
      day_pulse_next = 1'b0;
      field_clr      = 3'b000;
      in_run         = (mode_reg == RUN);
      // A mode change in the same cycle always drops the increment request.
      inc_ok         = bus.inc_i && !bus.mode_i;

      case (mode_reg)
         RUN:      if (bus.mode_i) mode_next = SET_HOUR;
         SET_HOUR: if (bus.mode_i) mode_next = SET_MIN;
         SET_MIN:  if (bus.mode_i) mode_next = RUN;
         default:  mode_next = RUN;
      endcase

      // Seconds only advance in RUN, and a simultaneous mode change drops the tick.
      field_en[0] = in_run && bus.seconds_pulse_i && !bus.mode_i;
      field_en[1] = in_run ? field_carry[0] : ((mode_reg == SET_MIN) && inc_ok);
      field_en[2] = in_run ? field_carry[1] : ((mode_reg == SET_HOUR) && inc_ok);

      // Entering SET_HOUR zeroes seconds, so RUN later resumes from 00.
      field_clr[0] = in_run && bus.mode_i;

      if (!bus.mode_i && ((mode_reg == SET_HOUR) || (mode_reg == SET_MIN))) begin
         blink_next = bus.seconds_pulse_i ? !blink_reg : blink_reg;
      end

      // Only a carry out of hours in RUN is a genuine day rollover.
      day_pulse_next = in_run && field_carry[2];
   end

   // Mode, blink and day-pulse registers.
   always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mode_reg      <= RUN;
         blink_reg     <= 1'b0;
         day_pulse_reg <= 1'b0;
      end else begin
         mode_reg      <= mode_next;
         blink_reg     <= blink_next;
         day_pulse_reg <= day_pulse_next;
      end
   end

   assign bus.seconds_bcd_o = field_value[0];
   assign bus.minutes_bcd_o = field_value[1];
   assign bus.hours_bcd_o   = field_value[2];
   assign bus.mode_o        = mode_reg;
   assign bus.blink_o       = blink_reg;
   assign bus.day_pulse_o   = day_pulse_reg;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed self-checking bench for watch_time_counter.
module tb_watch_time_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   chk_cnt = 0;
   int   err_cnt = 0;
   int   day_cnt = 0;
   int   day_base;

   watch_time_counter_if ifa ();
   watch_time_counter_if ifb ();

   watch_time_counter #(.RESET_HOURS(12), .RESET_MINUTES(0)) dut_a (
      .clk_100MHz_i (clk),
      .reset_n_i    (rst_n),
      .bus          (ifa.slave)
   );

   watch_time_counter #(.RESET_HOURS(7), .RESET_MINUTES(45)) dut_b (
      .clk_100MHz_i (clk),
      .reset_n_i    (rst_n),
      .bus          (ifb.slave)
   );

   always #5 clk = ~clk;

   // Count day pulses of dut_a, sampled on the falling edge.
   always @(negedge clk) begin
      if (ifa.day_pulse_o === 1'b1) day_cnt <= day_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("check %s: ok (%0h)", tag, obs);
      end
   endtask

   function automatic logic [31:0] time_a();
      return {8'h00, ifa.hours_bcd_o, ifa.minutes_bcd_o, ifa.seconds_bcd_o};
   endfunction

   // Holds the given inputs high for n consecutive cycles; returns on a falling edge.
   task automatic burst(input logic s, input logic m, input logic i, input int n);
      @(negedge clk);
      ifa.seconds_pulse_i = s;
      ifa.mode_i          = m;
      ifa.inc_i           = i;
      repeat (n) @(negedge clk);
      ifa.seconds_pulse_i = 1'b0;
      ifa.mode_i          = 1'b0;
      ifa.inc_i           = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      ifa.seconds_pulse_i = 1'b0; ifa.mode_i = 1'b0; ifa.inc_i = 1'b0;
      ifb.seconds_pulse_i = 1'b0; ifb.mode_i = 1'b0; ifb.inc_i = 1'b0;

      // Reset values for both parameter sets
      do_reset();
      check_val("reset_time_a", time_a(), 32'h120000);
      check_val("reset_mode_a", {30'd0, ifa.mode_o}, 32'd0);
      check_val("reset_blink_a", {31'd0, ifa.blink_o}, 32'd0);
      check_val("reset_day_a", {31'd0, ifa.day_pulse_o}, 32'd0);
      check_val("reset_time_b", {8'h00, ifb.hours_bcd_o, ifb.minutes_bcd_o, ifb.seconds_bcd_o}, 32'h074500);

      // Ticking: 09 -> 10 in BCD, then 61 total pulses
      burst(1, 0, 0, 9);
      check_val("sec_09", {24'd0, ifa.seconds_bcd_o}, 32'h09);
      burst(1, 0, 0, 1);
      check_val("sec_10_bcd", {24'd0, ifa.seconds_bcd_o}, 32'h10);
      burst(1, 0, 0, 51);
      check_val("tick_61", time_a(), 32'h120101);

      // Reach 12:34:56
      do_reset();
      burst(0, 1, 0, 1);
      burst(0, 1, 0, 1);
      burst(0, 0, 1, 34);
      burst(0, 1, 0, 1);
      burst(1, 0, 0, 56);
      check_val("set_start", time_a(), 32'h123456);

      // SET_HOUR: 13 increments wrap 12 -> 01
      burst(0, 1, 0, 1);
      check_val("sethour_mode", {30'd0, ifa.mode_o}, 32'd1);
      check_val("sethour_sec_clr", time_a(), 32'h123400);
      burst(0, 0, 1, 13);
      check_val("sethour_inc13", time_a(), 32'h013400);

      // Set-mode ticks toggle blink only
      burst(1, 0, 0, 1);
      check_val("blink_1", {31'd0, ifa.blink_o}, 32'd1);
      burst(1, 0, 0, 1);
      check_val("blink_0", {31'd0, ifa.blink_o}, 32'd0);
      burst(1, 0, 0, 1);
      check_val("blink_1b", {31'd0, ifa.blink_o}, 32'd1);
      check_val("setmode_ticks_time", time_a(), 32'h013400);

      // Collision in SET_HOUR: mode wins over inc
      burst(0, 1, 1, 1);
      check_val("col_modeinc_mode", {30'd0, ifa.mode_o}, 32'd2);
      check_val("col_modeinc_time", time_a(), 32'h013400);
      check_val("setmin_blink_clr", {31'd0, ifa.blink_o}, 32'd0);

      // SET_MIN: 30 increments wrap 34 -> 04, no hour carry
      burst(0, 0, 1, 30);
      check_val("setmin_inc30", time_a(), 32'h010400);

      // Back to RUN, counting resumes
      burst(0, 1, 0, 1);
      check_val("run_mode", {30'd0, ifa.mode_o}, 32'd0);
      check_val("run_blink", {31'd0, ifa.blink_o}, 32'd0);
      burst(1, 0, 0, 1);
      check_val("run_resume", time_a(), 32'h010401);

      // Rollover setup: hours wrap in set mode without a day pulse
      do_reset();
      day_base = day_cnt;
      burst(0, 1, 0, 1);
      burst(0, 0, 1, 12);
      check_val("sethour_wrap", {24'd0, ifa.hours_bcd_o}, 32'h00);
      burst(0, 0, 1, 23);
      burst(0, 1, 0, 1);
      burst(0, 0, 1, 59);
      burst(0, 1, 0, 1);
      check_val("roll_start", time_a(), 32'h235900);
      burst(1, 0, 0, 59);
      check_val("roll_2359_59", time_a(), 32'h235959);
      check_val("roll_no_early_day", day_cnt - day_base, 32'd0);
      burst(1, 0, 0, 1);
      check_val("roll_zero", time_a(), 32'h000000);
      check_val("roll_day_high", {31'd0, ifa.day_pulse_o}, 32'd1);
      @(negedge clk);
      check_val("roll_day_low", {31'd0, ifa.day_pulse_o}, 32'd0);
      burst(1, 0, 0, 1);
      check_val("roll_after", time_a(), 32'h000001);
      check_val("roll_day_count", day_cnt - day_base, 32'd1);

      // Collision in RUN at 10:10:30: mode wins, seconds clear
      do_reset();
      burst(0, 1, 0, 1);
      burst(0, 0, 1, 22);
      burst(0, 1, 0, 1);
      burst(0, 0, 1, 10);
      burst(0, 1, 0, 1);
      burst(1, 0, 0, 30);
      check_val("col_run_start", time_a(), 32'h101030);
      burst(1, 1, 0, 1);
      check_val("col_run_mode", {30'd0, ifa.mode_o}, 32'd1);
      check_val("col_run_time", time_a(), 32'h101000);

      // Collision in SET_MIN: return to RUN wins, tick dropped
      burst(0, 1, 0, 1);
      burst(1, 1, 0, 1);
      check_val("col_setmin_mode", {30'd0, ifa.mode_o}, 32'd0);
      check_val("col_setmin_time", time_a(), 32'h101000);

      // Asynchronous reset mid-cycle
      burst(1, 0, 0, 5);
      burst(0, 1, 0, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_time", time_a(), 32'h120000);
      check_val("async_mode", {30'd0, ifa.mode_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
